sc_frame_host: RTL and testbench

Host-side partner for the stochastic add/multiply core's serial pins.
- Transmit side: takes two 9-bit operands and streams them continuously as 10-bit serial frames onto the core's operand inputs (ui_in[0], ui_in[1]).
- Receive side: deserialises the core's three result lines (multiplier, adder, self-multiplier) and presents parallel results once per epoch, using the core's epoch pulse (uo_out[3]).
- Sits in the FPGA/test harness or an on-chip wrapper, clocked from the same clk and reset as the core.

---
 rtl/sc_frame_host.sv | 185 ++++++++++++++++++
 tb/tb_sc_frame_host.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sc_frame_host.sv
// sc_frame_host: host-side serial partner for the stochastic add/multiply core.
//   Transmit: streams a held 9-bit operand pair as continuous 10-bit frames, LSB first, with a 0 buffer bit.
//   Receive: deserialises the three result lines and latches them once per epoch, after a settle period.
// Ports:
//   clk, rst_n (asynchronous, active-high despite the name)
//   op_a/op_b/tx_valid/tx_ready : operand pair handshake, accepted on the last bit-time of a frame
//   sn_tx_a/sn_tx_b             : serial operands to core ui_in[0]/ui_in[1]
//   sn_rx_mul/add/smul          : serial results from core uo_out[0..2]
//   epoch_pulse                 : core epoch marker, uo_out[3]
//   res_mul/res_add/res_smul, rx_valid, epoch_cnt : latched results, update strobe, epoch count
//   frame_err                   : sticky buffer-bit framing error
// Optional feature macro: SC_RX_FRAMECHK_EN (buffer-bit check; frame_err tied 0 when undefined).
module sc_frame_host #(
  parameter int DATA_W        = 9,
  parameter int FRAME_LEN     = 10,
  parameter int RX_PHASE      = 1,
  parameter int SETTLE_FRAMES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              sn_tx_a,
  output logic              sn_tx_b,
  input  logic              sn_rx_mul,
  input  logic              sn_rx_add,
  input  logic              sn_rx_smul,
  input  logic              epoch_pulse,
  output logic [DATA_W-1:0] res_mul,
  output logic [DATA_W-1:0] res_add,
  output logic [DATA_W-1:0] res_smul,
  output logic              rx_valid,
  output logic [7:0]        epoch_cnt,
  output logic              frame_err
);

  localparam int BIT_W = $clog2(FRAME_LEN);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_LEN - 1);
  // Receive counter lags the transmit counter by RX_PHASE, so it starts that far behind 0.
  localparam logic [BIT_W-1:0] RX_START = BIT_W'((FRAME_LEN - (RX_PHASE % FRAME_LEN)) % FRAME_LEN);
  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_FRAMES);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  logic [BIT_W-1:0]  tx_bit;
  logic [BIT_W-1:0]  rx_bit;
  logic [DATA_W-1:0] held_a;
  logic [DATA_W-1:0] held_b;
  logic [DATA_W-1:0] sr_mul;
  logic [DATA_W-1:0] sr_add;
  logic [DATA_W-1:0] sr_smul;
  logic              rx_last;
  logic              frame_bad;
  logic              cap;
  state_t            state;
  state_t            state_nxt;
  logic [7:0]        settle_cnt;
  logic [7:0]        settle_nxt;

  // ---------------- transmit ----------------
  assign tx_ready = (tx_bit == LAST_BIT);
  assign sn_tx_a  = (tx_bit != LAST_BIT) ? held_a[tx_bit] : 1'b0;
  assign sn_tx_b  = (tx_bit != LAST_BIT) ? held_b[tx_bit] : 1'b0;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      tx_bit <= '0;
      held_a <= '0;
      held_b <= '0;
    end else begin
      tx_bit <= tx_ready ? '0 : tx_bit + BIT_W'(1);
      // Loading only on the last bit-time keeps every frame whole.
      if (tx_ready && tx_valid) begin
        held_a <= op_a;
        held_b <= op_b;
      end
    end
  end

  // ---------------- receive deserialiser ----------------
  assign rx_last = (rx_bit == LAST_BIT);

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      rx_bit  <= RX_START;
      sr_mul  <= '0;
      sr_add  <= '0;
      sr_smul <= '0;
    end else begin
      rx_bit <= rx_last ? '0 : rx_bit + BIT_W'(1);
      if (!rx_last) begin
        sr_mul  <= {sn_rx_mul,  sr_mul[DATA_W-1:1]};
        sr_add  <= {sn_rx_add,  sr_add[DATA_W-1:1]};
        sr_smul <= {sn_rx_smul, sr_smul[DATA_W-1:1]};
      end
    end
  end

`ifdef SC_RX_FRAMECHK_EN
  assign frame_bad = rx_last & (sn_rx_mul | sn_rx_add | sn_rx_smul);

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      frame_err <= 1'b0;
    end else if (frame_bad) begin
      frame_err <= 1'b1;
    end
  end
`else
  assign frame_bad = 1'b0;
  assign frame_err = 1'b0;
`endif

  // ---------------- epoch FSM ----------------
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state      <= IDLE;
      settle_cnt <= '0;
    end else begin
      state      <= state_nxt;
      settle_cnt <= settle_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    settle_nxt = settle_cnt;
    cap        = 1'b0;
    case (state)
      IDLE: begin
      end
      SETTLE: begin
        // The first buffer bit after the pulse closes the partial frame in
        // progress; each later one closes a whole discarded frame. CAPTURE is
        // entered once SETTLE_FRAMES whole frames have gone by.
        if (rx_last) begin
          if (settle_cnt == 8'd0) begin
            state_nxt = CAPTURE;
          end else begin
            settle_nxt = settle_cnt - 8'd1;
          end
        end
      end
      CAPTURE: begin
        if (rx_last) begin
          state_nxt = IDLE;
          cap       = !frame_bad;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // A new epoch always restarts settling; a capture completing on this same
    // cycle still goes through because cap is already decided above.
    if (epoch_pulse) begin
      state_nxt  = SETTLE;
      settle_nxt = SETTLE_LOAD;
    end
  end

  // ---------------- result registers ----------------
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      res_mul   <= '0;
      res_add   <= '0;
      res_smul  <= '0;
      rx_valid  <= 1'b0;
      epoch_cnt <= '0;
    end else begin
      rx_valid <= cap;
      if (cap) begin
        res_mul   <= sr_mul;
        res_add   <= sr_add;
        res_smul  <= sr_smul;
        epoch_cnt <= epoch_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_sc_frame_host.sv
`timescale 1ns/1ps
module tb_sc_frame_host;
  localparam int DW = 9;
  localparam int FL = 10;
  localparam int PH = 1;
  localparam int SF = 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] op_a, op_b;
  logic          tx_valid, tx_ready, sn_tx_a, sn_tx_b;
  logic          sn_rx_mul, sn_rx_add, sn_rx_smul, epoch_pulse;
  logic [DW-1:0] res_mul, res_add, res_smul;
  logic          rx_valid;
  logic [7:0]    epoch_cnt;
  logic          frame_err;

  sc_frame_host #(.DATA_W(DW), .FRAME_LEN(FL), .RX_PHASE(PH), .SETTLE_FRAMES(SF)) dut (
    .clk(clk), .rst_n(rst_n), .op_a(op_a), .op_b(op_b), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .sn_tx_a(sn_tx_a), .sn_tx_b(sn_tx_b),
    .sn_rx_mul(sn_rx_mul), .sn_rx_add(sn_rx_add), .sn_rx_smul(sn_rx_smul),
    .epoch_pulse(epoch_pulse), .res_mul(res_mul), .res_add(res_add), .res_smul(res_smul),
    .rx_valid(rx_valid), .epoch_cnt(epoch_cnt), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc;

  // behavioural model: held operands, current received frame words, epoch tracking
  logic [DW-1:0] m_held_a, m_held_b, m_res_mul, m_res_add, m_res_smul;
  logic          m_vld, m_err;
  logic [7:0]    m_cnt;
  bit            active;
  int            k;   // frame boundaries seen since the latest epoch pulse
  logic [DW-1:0] f_mul, f_add, f_smul;

  // stimulus controls
  bit            rnd_tx, rnd_rx, err_rnd, pulse_now, inj_add;
  int            pulse_pct;
  logic [DW-1:0] fx_mul, fx_add, fx_smul;

  // observations for literal checks
  int          vld_seen, vld_first, pulse_cyc, tx_ones, rec_start;
  int          ready_log[$];
  logic [19:0] rec_a, rec_b;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic bitof(logic [DW-1:0] w, int i);
    return w[i[3:0]];
  endfunction

  task automatic model_reset();
    cyc = 0;
    m_held_a = '0; m_held_b = '0;
    m_res_mul = '0; m_res_add = '0; m_res_smul = '0;
    m_vld = 1'b0; m_err = 1'b0; m_cnt = '0;
    active = 1'b0; k = 0;
    f_mul = '0; f_add = '0; f_smul = '0;
  endtask

  // One clock cycle, called at a negedge: compare, drive, advance model.
  task automatic step();
    int   p, r;
    logic bufbad;
    p = cyc % FL;
    r = (cyc + FL - PH) % FL;
    chk("tx_ready",  32'(tx_ready),  32'(p == FL-1));
    chk("sn_tx_a",   32'(sn_tx_a),   32'((p < DW) ? bitof(m_held_a, p) : 1'b0));
    chk("sn_tx_b",   32'(sn_tx_b),   32'((p < DW) ? bitof(m_held_b, p) : 1'b0));
    chk("rx_valid",  32'(rx_valid),  32'(m_vld));
    chk("res_mul",   32'(res_mul),   32'(m_res_mul));
    chk("res_add",   32'(res_add),   32'(m_res_add));
    chk("res_smul",  32'(res_smul),  32'(m_res_smul));
    chk("epoch_cnt", 32'(epoch_cnt), 32'(m_cnt));
    chk("frame_err", 32'(frame_err), 32'(m_err));

    if (rx_valid === 1'b1) begin
      vld_seen++;
      if (vld_first < 0) vld_first = cyc;
    end
    if (tx_ready === 1'b1) ready_log.push_back(cyc);
    if ((sn_tx_a | sn_tx_b) === 1'b1) tx_ones++;
    if (cyc >= rec_start && cyc < rec_start + 20) begin
      rec_a[5'(cyc - rec_start)] = sn_tx_a;
      rec_b[5'(cyc - rec_start)] = sn_tx_b;
    end

    if (rnd_tx) begin
      tx_valid = 1'($urandom_range(0, 1));
      op_a = DW'($urandom);
      op_b = DW'($urandom);
    end
    if (r == 0) begin
      if (rnd_rx) begin
        f_mul = DW'($urandom); f_add = DW'($urandom); f_smul = DW'($urandom);
      end else begin
        f_mul = fx_mul; f_add = fx_add; f_smul = fx_smul;
      end
    end
    if (r < DW) begin
      sn_rx_mul = bitof(f_mul, r);
      sn_rx_add = bitof(f_add, r);
      sn_rx_smul = bitof(f_smul, r);
    end else begin
      sn_rx_mul = 1'b0; sn_rx_add = inj_add; sn_rx_smul = 1'b0;
      inj_add = 1'b0;
      if (err_rnd && $urandom_range(0, 19) == 0) begin
        case ($urandom_range(0, 2))
          0: sn_rx_mul = 1'b1;
          1: sn_rx_add = 1'b1;
          default: sn_rx_smul = 1'b1;
        endcase
      end
    end
    epoch_pulse = pulse_now || (int'($urandom_range(0, 99)) < pulse_pct);
    if (pulse_now) pulse_cyc = cyc;
    pulse_now = 1'b0;

    // effect of the coming posedge
    if (p == FL-1 && tx_valid) begin
      m_held_a = op_a; m_held_b = op_b;
    end
    m_vld = 1'b0;
    if (r == FL-1) begin
      bufbad = sn_rx_mul | sn_rx_add | sn_rx_smul;
`ifdef SC_RX_FRAMECHK_EN
      if (bufbad) m_err = 1'b1;
`else
      bufbad = 1'b0;
`endif
      if (active) begin
        k++;
        // boundary 1 ends the partial frame, then SF settle frames, then the capture frame
        if (k == SF + 2) begin
          active = 1'b0;
          if (!bufbad) begin
            m_vld = 1'b1;
            m_res_mul = f_mul; m_res_add = f_add; m_res_smul = f_smul;
            m_cnt++;
          end
        end
      end
    end
    if (epoch_pulse) begin
      active = 1'b1;
      k = 0;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic until_r(int want);
    int n = 0;
    while ((cyc + FL - PH) % FL != want && n < 20) begin
      step();
      n++;
    end
  endtask

  task automatic until_capture();
    int n = 0;
    while (!(active && k == SF + 1) && n < 60) begin
      step();
      n++;
    end
    if (n >= 60) begin
      total++; bad++;
      $display("FAIL capture_wait: timed out after %0d cycles, want capture frame", n);
    end
  endtask

  task automatic chk_zero_outputs(string tag);
    chk({tag, "_res_mul"},   32'(res_mul),   32'h0);
    chk({tag, "_res_add"},   32'(res_add),   32'h0);
    chk({tag, "_res_smul"},  32'(res_smul),  32'h0);
    chk({tag, "_rx_valid"},  32'(rx_valid),  32'h0);
    chk({tag, "_epoch_cnt"}, 32'(epoch_cnt), 32'h0);
    chk({tag, "_frame_err"}, 32'(frame_err), 32'h0);
    chk({tag, "_sn_tx_a"},   32'(sn_tx_a),   32'h0);
    chk({tag, "_tx_ready"},  32'(tx_ready),  32'h0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1; tx_valid = 1'b0; op_a = '0; op_b = '0;
    sn_rx_mul = 1'b0; sn_rx_add = 1'b0; sn_rx_smul = 1'b0; epoch_pulse = 1'b0;
    rnd_tx = 0; rnd_rx = 0; err_rnd = 0; pulse_now = 0; inj_add = 0; pulse_pct = 0;
    fx_mul = '0; fx_add = '0; fx_smul = '0;
    rec_start = -100; vld_first = -1; vld_seen = 0; tx_ones = 0; pulse_cyc = 0;
    rec_a = '0; rec_b = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk_zero_outputs("reset");
    rst_n = 1'b0;
    model_reset();

    // idle stream: zero frames, tx_ready at 9, 19, 29
    repeat (30) step();
    chk("idle_ready_count", 32'(ready_log.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      chk("idle_ready_at", 32'((i < ready_log.size()) ? ready_log[i] : -1), 32'(9 + 10 * i));
    chk("idle_tx_ones", 32'(tx_ones), 32'd0);

    // operand pair accepted at cycle 39, frames from cycle 40
    op_a = 9'h155; op_b = 9'h0F3; tx_valid = 1'b1;
    rec_start = 40;
    repeat (30) step();
    chk("frame_a_bits", 32'(rec_a), 32'h55555);
    chk("frame_b_bits", 32'(rec_b), 32'h3CCF3);
    tx_valid = 1'b0;

    // loopback single epoch
    fx_mul = 9'h1A2; fx_add = 9'h080; fx_smul = 9'h0FF;
    repeat (10) step();
    until_r(3);
    vld_seen = 0; vld_first = -1; pulse_now = 1'b1;
    repeat (40) step();
    chk("ep1_vld_count", 32'(vld_seen), 32'd1);
    chk("ep1_latency",   32'(vld_first - pulse_cyc), 32'd27);
    chk("ep1_res_mul",   32'(res_mul),  32'h1A2);
    chk("ep1_res_add",   32'(res_add),  32'h080);
    chk("ep1_res_smul",  32'(res_smul), 32'h0FF);
    chk("ep1_epoch_cnt", 32'(epoch_cnt), 32'd1);

    // second pulse during SETTLE restarts the epoch
    fx_mul = 9'h0AA; fx_add = 9'h155; fx_smul = 9'h001;
    repeat (10) step();
    until_r(3);
    vld_seen = 0; vld_first = -1; pulse_now = 1'b1;
    repeat (8) step();
    pulse_now = 1'b1;
    repeat (40) step();
    chk("ep2_vld_count", 32'(vld_seen), 32'd1);
    chk("ep2_latency",   32'(vld_first - pulse_cyc), 32'd29);
    chk("ep2_res_mul",   32'(res_mul), 32'h0AA);
    chk("ep2_epoch_cnt", 32'(epoch_cnt), 32'd2);

    // buffer-bit 1 on the add line at the end of the capture frame
    until_r(3);
    vld_seen = 0; pulse_now = 1'b1;
    step();
    until_capture();
    inj_add = 1'b1;
    repeat (20) step();
`ifdef SC_RX_FRAMECHK_EN
    chk("ferr_vld_count", 32'(vld_seen), 32'd0);
    chk("ferr_flag",      32'(frame_err), 32'd1);
    chk("ferr_epoch_cnt", 32'(epoch_cnt), 32'd2);
`else
    chk("ferr_vld_count", 32'(vld_seen), 32'd1);
    chk("ferr_flag",      32'(frame_err), 32'd0);
    chk("ferr_epoch_cnt", 32'(epoch_cnt), 32'd3);
`endif

    // randomized traffic
    rnd_tx = 1; rnd_rx = 1; err_rnd = 1; pulse_pct = 2;
    repeat (3000) step();
`ifdef SC_RX_FRAMECHK_EN
    chk("ferr_sticky", 32'(frame_err), 32'd1);
`endif

    // asynchronous reset during CAPTURE
    pulse_pct = 0; err_rnd = 0;
    repeat (40) step();
    until_r(3);
    pulse_now = 1'b1;
    step();
    until_capture();
    repeat (4) step();
    #2 rst_n = 1'b1;
    #1 chk_zero_outputs("midrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    vld_seen = 0;
    ready_log.delete();
    repeat (40) step();
    chk("midrst_vld_count", 32'(vld_seen), 32'd0);
    chk("midrst_first_ready", 32'((ready_log.size() > 0) ? ready_log[0] : -1), 32'd9);
    chk("midrst_epoch_cnt", 32'(epoch_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
